// File: rtl/cv32e40x_instr_obi_responder.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40x_instr_obi_responder
// Purpose  : OBI instruction-fetch responder with preloadable word memory,
//            programmable response latency and bounded outstanding depth.
// Options  : CV32E40X_IMEM_GNT_STALL_EN adds stall_cycles_i grant back-off.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40x_instr_obi_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_wdata_i,
`ifdef CV32E40X_IMEM_GNT_STALL_EN
  input  logic [3:0]                   stall_cycles_i,
`endif
  output logic [3:0]                   outstanding_o
);

  localparam int unsigned c_AW     = $clog2(MEM_WORDS);
  localparam int unsigned c_CD_W   = $clog2(RESP_LATENCY + 1);
  localparam int unsigned c_QC_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] c_END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;
  // Stored countdown is the number of cycles still to go as seen from the cycle after the push.
  localparam logic [c_CD_W-1:0] c_PUSH_CD = c_CD_W'(RESP_LATENCY - 1);

  logic [31:0]                            r_mem [MEM_WORDS];

  logic [MAX_OUTSTANDING-1:0][31:0]       r_q_data;
  logic [MAX_OUTSTANDING-1:0]             r_q_err;
  logic [MAX_OUTSTANDING-1:0][c_CD_W-1:0] r_q_cd;
  logic [c_QC_W-1:0]                      r_q_cnt;

  logic [MAX_OUTSTANDING-1:0][31:0]       w_nq_data;
  logic [MAX_OUTSTANDING-1:0]             w_nq_err;
  logic [MAX_OUTSTANDING-1:0][c_CD_W-1:0] w_nq_cd;
  logic [c_QC_W-1:0]                      w_push_idx;

  logic [3:0]  r_count;
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;

  logic [c_AW-1:0] w_idx;
  logic            w_addr_err;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_new_data;
  logic            w_stall;
  logic            w_accept;
  logic            w_head_ready;
  logic            w_bypass;
  logic            w_pop;
  logic            w_push;

  // ---------------------------------------------------------------- decode
  assign w_addr_err = (instr_addr_i[1:0] != 2'b00)
                   || ({1'b0, instr_addr_i} < {1'b0, BASE_ADDR})
                   || ({1'b0, instr_addr_i} >= c_END_ADDR);
  assign w_idx      = c_AW'((instr_addr_i - BASE_ADDR) >> 2);
  // A preload to the fetched word in the grant cycle wins over the stored word.
  assign w_rd_word  = (load_we_i && (load_addr_i == w_idx)) ? load_wdata_i : r_mem[w_idx];
  assign w_new_data = w_addr_err ? 32'h0 : w_rd_word;

  // ---------------------------------------------------------------- grant
`ifdef CV32E40X_IMEM_GNT_STALL_EN
  logic [3:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 4'd0;
    end else if (w_accept) begin
      r_stall_cnt <= stall_cycles_i;
    end else if (r_stall_cnt != 4'd0) begin
      r_stall_cnt <= r_stall_cnt - 4'd1;
    end
  end

  assign w_stall = (r_stall_cnt != 4'd0);
`else
  assign w_stall = 1'b0;
`endif

  assign instr_gnt_o = instr_req_i && !rst && (r_count < 4'(MAX_OUTSTANDING)) && !w_stall;
  assign w_accept    = instr_req_i && instr_gnt_o;

  // ---------------------------------------------------------------- queue control
  assign w_head_ready = (r_q_cnt != '0) && (r_q_cd[0] <= c_CD_W'(1));
  // Single-cycle latency with nothing queued goes straight to the response register.
  assign w_bypass     = (r_q_cnt == '0) && w_accept && (RESP_LATENCY == 1);
  assign w_pop        = w_head_ready;
  assign w_push       = w_accept && !w_bypass;
  assign w_push_idx   = r_q_cnt - c_QC_W'(w_pop);

  always_comb begin
    w_nq_data = r_q_data;
    w_nq_err  = r_q_err;
    w_nq_cd   = r_q_cd;
    if (w_pop) begin
      w_nq_data = r_q_data >> 32;
      w_nq_err  = r_q_err >> 1;
      w_nq_cd   = r_q_cd >> c_CD_W;
    end
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (w_nq_cd[i] != '0) begin
        w_nq_cd[i] = w_nq_cd[i] - c_CD_W'(1);
      end
      if (w_push && (w_push_idx == c_QC_W'(i))) begin
        w_nq_data[i] = w_new_data;
        w_nq_err[i]  = w_addr_err;
        w_nq_cd[i]   = c_PUSH_CD;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_q_data <= w_nq_data;
    r_q_err  <= w_nq_err;
    r_q_cd   <= w_nq_cd;
  end

  always_ff @(posedge clk) begin
    if (load_we_i) begin
      r_mem[load_addr_i] <= load_wdata_i;
    end
  end

  // ---------------------------------------------------------------- counters and response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_cnt  <= '0;
      r_count  <= 4'd0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_q_cnt <= r_q_cnt + c_QC_W'(w_push) - c_QC_W'(w_pop);
      // An entry stays outstanding through the cycle its rvalid is shown.
      r_count <= r_count + {3'b000, w_accept} - {3'b000, r_rvalid};
      if (w_pop) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_q_data[0];
        r_err    <= r_q_err[0];
      end else if (w_bypass) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_new_data;
        r_err    <= w_addr_err;
      end else begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign instr_rvalid_o = r_rvalid;
  assign instr_rdata_o  = r_rdata;
  assign instr_err_o    = r_err;
  assign outstanding_o  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_instr_obi_responder.sv
`default_nettype none
// Bench for cv32e40x_instr_obi_responder: two instances (LAT=1 at base 0, LAT=4 at base 0x1000)
// checked by response scoreboards plus vector tables for grant/outstanding sequences.
module tb_cv32e40x_instr_obi_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Instance A: 1024 words, base 0, depth 2, latency 1
  logic        a_req = 1'b0, a_gnt, a_rvalid, a_err, a_lwe = 1'b0;
  logic [31:0] a_addr = '0, a_rdata, a_ld = '0;
  logic [9:0]  a_la = '0;
  logic [3:0]  a_out;
  // Instance B: 16 words, base 0x1000, depth 2, latency 4
  logic        b_req = 1'b0, b_gnt, b_rvalid, b_err, b_lwe = 1'b0;
  logic [31:0] b_addr = '0, b_rdata, b_ld = '0;
  logic [3:0]  b_la = '0;
  logic [3:0]  b_out;
`ifdef CV32E40X_IMEM_GNT_STALL_EN
  logic [3:0]  a_stall = 4'd0;
  logic [3:0]  b_stall = 4'd0;
`endif

  cv32e40x_instr_obi_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .MAX_OUTSTANDING(2), .RESP_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
    .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .instr_err_o(a_err),
    .load_we_i(a_lwe), .load_addr_i(a_la), .load_wdata_i(a_ld),
`ifdef CV32E40X_IMEM_GNT_STALL_EN
    .stall_cycles_i(a_stall),
`endif
    .outstanding_o(a_out)
  );

  cv32e40x_instr_obi_responder #(
    .MEM_WORDS(16), .BASE_ADDR(32'h0000_1000), .MAX_OUTSTANDING(2), .RESP_LATENCY(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
    .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .instr_err_o(b_err),
    .load_we_i(b_lwe), .load_addr_i(b_la), .load_wdata_i(b_ld),
`ifdef CV32E40X_IMEM_GNT_STALL_EN
    .stall_cycles_i(b_stall),
`endif
    .outstanding_o(b_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboards: expected data, error flag and the cycle rvalid must appear in.
  logic [31:0] qa_d[$], qb_d[$];
  logic        qa_e[$], qb_e[$];
  int          qa_c[$], qb_c[$];
  int          last_a = -100, last_b = -100;

  task automatic push_a(input logic [31:0] d, input logic e, input int gcyc);
    int ec;
    ec = gcyc + 1;
    if (ec <= last_a) ec = last_a + 1;
    last_a = ec;
    qa_d.push_back(d); qa_e.push_back(e); qa_c.push_back(ec);
  endtask

  task automatic push_b(input logic [31:0] d, input logic e, input int gcyc);
    int ec;
    ec = gcyc + 4;
    if (ec <= last_b) ec = last_b + 1;
    last_b = ec;
    qb_d.push_back(d); qb_e.push_back(e); qb_c.push_back(ec);
  endtask

  always @(negedge clk) begin
    if (a_rvalid === 1'b1) begin
      if (qa_d.size() == 0) chk("a_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        chk("a_rdata", a_rdata, qa_d.pop_front());
        chk("a_err", 32'(a_err), 32'(qa_e.pop_front()));
        chk("a_rvalid_cycle", 32'(cyc), 32'(qa_c.pop_front()));
      end
    end else if (qa_c.size() != 0 && qa_c[0] <= cyc) begin
      chk("a_missing_rvalid", 32'(cyc), 32'(qa_c[0]));
      void'(qa_d.pop_front()); void'(qa_e.pop_front()); void'(qa_c.pop_front());
    end
    if (b_rvalid === 1'b1) begin
      if (qb_d.size() == 0) chk("b_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        chk("b_rdata", b_rdata, qb_d.pop_front());
        chk("b_err", 32'(b_err), 32'(qb_e.pop_front()));
        chk("b_rvalid_cycle", 32'(cyc), 32'(qb_c.pop_front()));
      end
    end else if (qb_c.size() != 0 && qb_c[0] <= cyc) begin
      chk("b_missing_rvalid", 32'(cyc), 32'(qb_c[0]));
      void'(qb_d.pop_front()); void'(qb_e.pop_front()); void'(qb_c.pop_front());
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [9:0]  la;
    logic [31:0] ld;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  typedef struct {
    logic req;
    logic gnt;
    logic [3:0] out;
    logic rv;
  } seq_t;

  vec_t vecs[10];
  seq_t t2[12];

  task automatic fetch_a(input vec_t v);
    int n;
    @(negedge clk);
    a_req = 1'b1; a_addr = v.addr; a_lwe = v.we; a_la = v.la; a_ld = v.ld;
    #1;
    n = 0;
    while (!a_gnt && n < 20) begin @(negedge clk); #1; n++; end
    if (a_gnt) push_a(v.exp_d, v.exp_e, cyc);
    else chk("a_gnt_timeout", 32'(a_gnt), 32'd1);
  endtask

  task automatic fetch_b(input logic [31:0] addr, input logic [31:0] d, input logic e);
    int n;
    @(negedge clk);
    b_req = 1'b1; b_addr = addr;
    #1;
    n = 0;
    while (!b_gnt && n < 20) begin @(negedge clk); #1; n++; end
    if (b_gnt) push_b(d, e, cyc);
    else chk("b_gnt_timeout", 32'(b_gnt), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa_d.size() != 0 || qb_d.size() != 0) && n < 60) begin @(negedge clk); n++; end
    if (qa_d.size() != 0 || qb_d.size() != 0) begin
      chk("drain_timeout", 32'(qa_d.size() + qb_d.size()), 32'd0);
      qa_d.delete(); qa_e.delete(); qa_c.delete();
      qb_d.delete(); qb_e.delete(); qb_c.delete();
    end
  endtask

  // Holds req high for 8 cycles on A and checks the grant/outstanding pattern.
  task automatic burst_a(input int spacing);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_req = 1'b1; a_addr = 32'h8; a_lwe = 1'b0;
      #1;
      chk("burst_gnt", 32'(a_gnt), 32'((k % spacing) == 0));
      chk("burst_outstanding", 32'(a_out), 32'((spacing == 1) ? (k != 0) : ((k % spacing) == 1)));
      if (a_gnt) push_a(32'h15, 1'b0, cyc);
    end
    @(negedge clk);
    a_req = 1'b0;
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 10'd0, 32'h0, 32'h0000_0013, 1'b0};
    vecs[1] = '{32'h0000_0004, 1'b0, 10'd0, 32'h0, 32'h0000_0014, 1'b0};
    vecs[2] = '{32'h0000_0002, 1'b0, 10'd0, 32'h0, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_1000, 1'b0, 10'd0, 32'h0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0014, 1'b1, 10'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{32'h0000_0014, 1'b0, 10'd0, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{32'h0000_0FFC, 1'b0, 10'd0, 32'h0, 32'hCAFE_0001, 1'b0};
    vecs[7] = '{32'hFFFF_FFFC, 1'b0, 10'd0, 32'h0, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'h0000_0008, 1'b0, 10'd0, 32'h0, 32'h0000_0015, 1'b0};
    vecs[9] = '{32'h0000_000C, 1'b0, 10'd0, 32'h0, 32'h0000_0016, 1'b0};

    t2[0]  = '{1'b1, 1'b1, 4'd0, 1'b0};
    t2[1]  = '{1'b1, 1'b1, 4'd1, 1'b0};
    t2[2]  = '{1'b1, 1'b0, 4'd2, 1'b0};
    t2[3]  = '{1'b1, 1'b0, 4'd2, 1'b0};
    t2[4]  = '{1'b1, 1'b0, 4'd2, 1'b1};
    t2[5]  = '{1'b1, 1'b1, 4'd1, 1'b1};
    t2[6]  = '{1'b1, 1'b1, 4'd1, 1'b0};
    t2[7]  = '{1'b1, 1'b0, 4'd2, 1'b0};
    t2[8]  = '{1'b0, 1'b0, 4'd2, 1'b0};
    t2[9]  = '{1'b0, 1'b0, 4'd2, 1'b1};
    t2[10] = '{1'b0, 1'b0, 4'd1, 1'b1};
    t2[11] = '{1'b0, 1'b0, 4'd0, 1'b0};

    // Reset state, with requests asserted to confirm the grant is suppressed.
    a_req = 1'b1; b_req = 1'b1; b_addr = 32'h1000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_a_outstanding", 32'(a_out), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("rst_b_outstanding", 32'(b_out), 32'd0);
    @(negedge clk);
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;

    // Preload both memories.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_lwe = 1'b1; a_la = 10'(i); a_ld = 32'h13 + 32'(i);
      b_lwe = 1'b1; b_la = 4'(i);  b_ld = 32'hB000_0000 + 32'(i);
    end
    @(negedge clk);
    a_la = 10'd1023; a_ld = 32'hCAFE_0001;
    b_la = 4'd15;    b_ld = 32'hB000_00FF;
    @(negedge clk);
    a_lwe = 1'b0; b_lwe = 1'b0;

    // Vector table on A: back-to-back fetches, errors, write-first, boundaries.
    for (int i = 0; i < 10; i++) fetch_a(vecs[i]);
    @(negedge clk);
    a_req = 1'b0; a_lwe = 1'b0;
    drain();

    // Grant throughput with request held high.
`ifdef CV32E40X_IMEM_GNT_STALL_EN
    a_stall = 4'd3;
    burst_a(4);
    a_stall = 4'd0;
`endif
    burst_a(1);

    // Address window boundaries on B (non-zero base).
    fetch_b(32'h0000_0FFC, 32'h0, 1'b1);
    fetch_b(32'h0000_1040, 32'h0, 1'b1);
    fetch_b(32'h0000_103C, 32'hB000_00FF, 1'b0);
    fetch_b(32'h0000_1002, 32'h0, 1'b1);
    fetch_b(32'h0000_1008, 32'hB000_0002, 1'b0);
    @(negedge clk);
    b_req = 1'b0;
    drain();

    // Depth-limited grants at latency 4.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      b_req = t2[k].req; b_addr = 32'h1000;
      #1;
      chk("t2_gnt", 32'(b_gnt), 32'(t2[k].gnt));
      chk("t2_outstanding", 32'(b_out), 32'(t2[k].out));
      chk("t2_rvalid", 32'(b_rvalid), 32'(t2[k].rv));
      if (b_gnt) push_b(32'hB000_0000, 1'b0, cyc);
    end
    b_req = 1'b0;
    drain();

    // Reset with two responses pending: both must be dropped.
    @(negedge clk);
    b_req = 1'b1; b_addr = 32'h1004;
    #1 chk("rst5_gnt0", 32'(b_gnt), 32'd1);
    @(negedge clk);
    #1 chk("rst5_gnt1", 32'(b_gnt), 32'd1);
    @(negedge clk);
    #1 chk("rst5_outstanding_pre", 32'(b_out), 32'd2);
    b_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    b_req = 1'b1;
    #1;
    chk("rst5_gnt_in_rst", 32'(b_gnt), 32'd0);
    chk("rst5_outstanding", 32'(b_out), 32'd0);
    chk("rst5_rvalid", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0; b_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("rst5_quiet_rvalid", 32'(b_rvalid), 32'd0);
      chk("rst5_quiet_outstanding", 32'(b_out), 32'd0);
    end
    fetch_b(32'h0000_1004, 32'hB000_0001, 1'b0);
    fetch_b(32'h0000_100C, 32'hB000_0003, 1'b0);
    @(negedge clk);
    b_req = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
